// File: rtl/wb_sram_responder_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM responder.
package wb_sram_responder_pkg;

  localparam int WB_ADDR_W = 24;
  localparam int WB_DATA_W = 16;

  localparam int BURST_LEN_1 = 1;
  localparam int BURST_LEN_4 = 4;
  localparam int BURST_LEN_8 = 8;

  localparam logic [1:0] BURST_LOG2_1 = 2'd0;
  localparam logic [1:0] BURST_LOG2_4 = 2'd2;
  localparam logic [1:0] BURST_LOG2_8 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WR_ACK    = 2'd1,
    ST_RD_STREAM = 2'd2,
    ST_ERR       = 2'd3
  } wb_state_e;

  // The 8-beat request wins when both burst flags are raised.
  function automatic logic [1:0] burst_log2(input logic b4, input logic b8);
    if (b8)      return BURST_LOG2_8;
    else if (b4) return BURST_LOG2_4;
    else         return BURST_LOG2_1;
  endfunction

endpackage

// File: rtl/wb_sram_burst_addr.sv
// Beat counter and wrapping halfword address generator for read bursts.
module wb_sram_burst_addr
  import wb_sram_responder_pkg::*;
#(
  parameter int SRAM_AW = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [SRAM_AW:0]   i_start_hw,
  input  logic [1:0]         i_len_log2,
  input  logic               i_advance,
  output logic [SRAM_AW-1:0] o_next_addr,
  output logic               o_lane,
  output logic               o_last
);

  logic [SRAM_AW:0] cur_hw_q, cur_hw_d;
  logic [3:0]       rem_q, rem_d;
  logic [2:0]       mask_q, mask_d;
  logic [SRAM_AW:0] mask_ext;
  logic [SRAM_AW:0] next_hw;
  logic [3:0]       len_ld;

  // Only the low log2(N) bits step; the upper bits pin the N-aligned block.
  assign mask_ext = {{(SRAM_AW-2){1'b0}}, mask_q};
  assign next_hw  = (cur_hw_q & ~mask_ext) | ((cur_hw_q + (SRAM_AW+1)'(1)) & mask_ext);

  always_comb begin
    case (i_len_log2)
      BURST_LOG2_8: len_ld = 4'(BURST_LEN_8);
      BURST_LOG2_4: len_ld = 4'(BURST_LEN_4);
      default:      len_ld = 4'(BURST_LEN_1);
    endcase
  end

  always_comb begin
    cur_hw_d = cur_hw_q;
    rem_d    = rem_q;
    mask_d   = mask_q;
    if (i_load) begin
      cur_hw_d = i_start_hw;
      rem_d    = len_ld;
      mask_d   = 3'(len_ld - 4'd1);
    end else if (i_advance) begin
      cur_hw_d = next_hw;
      rem_d    = rem_q - 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cur_hw_q <= '0;
      rem_q    <= '0;
      mask_q   <= '0;
    end else begin
      cur_hw_q <= cur_hw_d;
      rem_q    <= rem_d;
      mask_q   <= mask_d;
    end
  end

  assign o_next_addr = next_hw[SRAM_AW:1];
  assign o_lane      = cur_hw_q[0];
  assign o_last      = (rem_q == 4'd1);

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone 16-bit responder backed by a 32-bit single-port SRAM, with wrapping read bursts.
// Window check and wb_err are built only with WB_SRAM_RESPONDER_WINDOW_CHECK_EN defined.
//   state        | meaning
//   ST_IDLE      | sample cyc&stb, drive SRAM controls for the accepted access
//   ST_WR_ACK    | single-cycle write acknowledge
//   ST_RD_STREAM | one ack per cycle, next burst address issued alongside
//   ST_ERR       | single-cycle error termination (window check builds only)
module wb_sram_responder
  import wb_sram_responder_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int BASE_HI = 0,
  parameter int SRAM_AW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 wb_cyc,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  input  logic [ADDR_W-1:0]    wb_adr,
  input  logic [WB_DATA_W-1:0] wb_i_dat,
  input  logic [1:0]           wb_sel,
  input  logic                 wb_4_burst,
  input  logic                 wb_8_burst,
  output logic [WB_DATA_W-1:0] wb_o_dat,
  output logic                 wb_ack,
  output logic                 wb_err,
  output logic                 o_sram_clk,
  output logic                 o_sram_csb,
  output logic                 o_sram_web,
  output logic [3:0]           o_sram_wmask,
  output logic [SRAM_AW-1:0]   o_sram_addr,
  output logic [31:0]          o_sram_din,
  input  logic [31:0]          i_sram_dout
);

  localparam int HI_W = ADDR_W - SRAM_AW - 1;

  wb_state_e          state_q, state_d;
  logic               req;
  logic               hit;
  logic               ba_load;
  logic               ba_adv;
  logic               ba_lane;
  logic               ba_last;
  logic [SRAM_AW-1:0] ba_next;

  // Reset gates the request so the SRAM is deselected the instant rst asserts.
  assign req = i_rst & wb_cyc & wb_stb;

`ifdef WB_SRAM_RESPONDER_WINDOW_CHECK_EN
  logic err_c;
  assign hit    = (wb_adr[ADDR_W-1:SRAM_AW+1] == HI_W'(BASE_HI));
  assign wb_err = err_c;
`else
  logic unused_adr_hi;
  assign unused_adr_hi = ^(wb_adr[ADDR_W-1:SRAM_AW+1] ^ HI_W'(BASE_HI));
  assign hit    = 1'b1;
  assign wb_err = 1'b0;
`endif

  wb_sram_burst_addr #(.SRAM_AW(SRAM_AW)) u_burst_addr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (ba_load),
    .i_start_hw  (wb_adr[SRAM_AW:0]),
    .i_len_log2  (wb_we ? BURST_LOG2_1 : burst_log2(wb_4_burst, wb_8_burst)),
    .i_advance   (ba_adv),
    .o_next_addr (ba_next),
    .o_lane      (ba_lane),
    .o_last      (ba_last)
  );

  always_comb begin
    state_d      = state_q;
    wb_ack       = 1'b0;
`ifdef WB_SRAM_RESPONDER_WINDOW_CHECK_EN
    err_c        = 1'b0;
`endif
    o_sram_csb   = 1'b1;
    o_sram_web   = 1'b1;
    o_sram_wmask = 4'b0000;
    o_sram_addr  = wb_adr[SRAM_AW:1];
    ba_load      = 1'b0;
    ba_adv       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && hit) begin
          ba_load    = 1'b1;
          o_sram_csb = 1'b0;
          if (wb_we) begin
            o_sram_web   = 1'b0;
            o_sram_wmask = wb_adr[0] ? {wb_sel, 2'b00} : {2'b00, wb_sel};
            state_d      = ST_WR_ACK;
          end else begin
            state_d = ST_RD_STREAM;
          end
        end
`ifdef WB_SRAM_RESPONDER_WINDOW_CHECK_EN
        else if (req) begin
          state_d = ST_ERR;
        end
`endif
      end
      ST_WR_ACK: begin
        wb_ack  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD_STREAM: begin
        if (wb_cyc && wb_stb) begin
          wb_ack = 1'b1;
          if (ba_last) begin
            state_d = ST_IDLE;
          end else begin
            o_sram_csb  = 1'b0;
            o_sram_addr = ba_next;
            ba_adv      = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef WB_SRAM_RESPONDER_WINDOW_CHECK_EN
      ST_ERR: begin
        err_c   = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign wb_o_dat   = wb_ack ? (ba_lane ? i_sram_dout[31:16] : i_sram_dout[15:0]) : '0;
  assign o_sram_din = {wb_i_dat, wb_i_dat};
  assign o_sram_clk = i_clk;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Self-checking bench: halfword-array reference model, per-cycle compare, directed plus random traffic.
module tb_wb_sram_responder;
  import wb_sram_responder_pkg::*;

  localparam int ADDR_W  = 24;
  localparam int SRAM_AW = 8;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b0;
  logic                 wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [ADDR_W-1:0]    wb_adr = '0;
  logic [15:0]          wb_i_dat = '0;
  logic [1:0]           wb_sel = '0;
  logic                 wb_4_burst = 1'b0, wb_8_burst = 1'b0;
  logic [15:0]          wb_o_dat;
  logic                 wb_ack, wb_err;
  logic                 o_sram_clk, o_sram_csb, o_sram_web;
  logic [3:0]           o_sram_wmask;
  logic [SRAM_AW-1:0]   o_sram_addr;
  logic [31:0]          o_sram_din;
  logic [31:0]          i_sram_dout = '0;

  wb_sram_responder #(.ADDR_W(ADDR_W), .BASE_HI(0), .SRAM_AW(SRAM_AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_i_dat(wb_i_dat), .wb_sel(wb_sel), .wb_4_burst(wb_4_burst),
    .wb_8_burst(wb_8_burst), .wb_o_dat(wb_o_dat), .wb_ack(wb_ack), .wb_err(wb_err),
    .o_sram_clk(o_sram_clk), .o_sram_csb(o_sram_csb), .o_sram_web(o_sram_web),
    .o_sram_wmask(o_sram_wmask), .o_sram_addr(o_sram_addr), .o_sram_din(o_sram_din),
    .i_sram_dout(i_sram_dout)
  );

  always #5 i_clk = ~i_clk;

  // SRAM macro: synchronous write with byte mask, registered read data.
  logic [31:0] sram [0:255];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  always @(posedge o_sram_clk) begin
    if (!o_sram_csb) begin
      if (!o_sram_web) sram[o_sram_addr] <= merge(sram[o_sram_addr], o_sram_din, o_sram_wmask);
      else             i_sram_dout <= sram[o_sram_addr];
    end
  end

  // Reference model: the window as a flat array of halfwords.
  logic [15:0] ref_mem [0:511];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic        chk_en = 1'b0;
  logic        exp_ack, exp_err, exp_csb, exp_web, dat_chk;
  logic [15:0] exp_dat;
  logic [3:0]  exp_wmask;
  logic [7:0]  exp_addr;
  logic [15:0] got [$];

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("ack", wb_ack, exp_ack);
      check("err", wb_err, exp_err);
      check("csb", o_sram_csb, exp_csb);
      if (dat_chk) check("rdata", wb_o_dat, exp_dat);
      if (!exp_csb) begin
        check("web", o_sram_web, exp_web);
        check("sram_addr", o_sram_addr, exp_addr);
        if (!exp_web) check("wmask", o_sram_wmask, exp_wmask);
      end
      if (wb_ack) got.push_back(wb_o_dat);
    end
  end

  task automatic set_idle_exp();
    exp_ack = 1'b0; exp_err = 1'b0; exp_csb = 1'b1; exp_web = 1'b1;
    dat_chk = 1'b1; exp_dat = '0; exp_wmask = '0; exp_addr = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic bit is_miss(input logic [ADDR_W-1:0] a);
`ifdef WB_SRAM_RESPONDER_WINDOW_CHECK_EN
    return a[ADDR_W-1:9] != '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int wrap(input int a, input int n, input int j);
    return ((a & ~(n - 1)) | ((a + j) & (n - 1))) & 511;
  endfunction

  task automatic bus_idle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_4_burst = 1'b0; wb_8_burst = 1'b0;
    set_idle_exp();
    tick();
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] adr, input logic [15:0] d, input logic [1:0] sel,
                          input logic b4, input logic b8);
    int a;
    a = int'(adr[8:0]);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_i_dat = d; wb_sel = sel;
    wb_4_burst = b4; wb_8_burst = b8;
    set_idle_exp();
    if (!is_miss(adr)) begin
      exp_csb = 1'b0; exp_web = 1'b0; exp_addr = adr[8:1];
      exp_wmask = adr[0] ? {sel, 2'b00} : {2'b00, sel};
    end
    tick();
    set_idle_exp();
    if (is_miss(adr)) exp_err = 1'b1;
    else begin
      exp_ack = 1'b1; dat_chk = 1'b0;
      if (sel[0]) ref_mem[a][7:0]  = d[7:0];
      if (sel[1]) ref_mem[a][15:8] = d[15:8];
    end
    tick();
    bus_idle();
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] adr, input logic b4, input logic b8, input int abort_k);
    int a, n;
    a = int'(adr[8:0]);
    n = b8 ? 8 : (b4 ? 4 : 1);
    got.delete();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr; wb_sel = 2'b11;
    wb_4_burst = b4; wb_8_burst = b8;
    set_idle_exp();
    if (!is_miss(adr)) begin
      exp_csb = 1'b0; exp_web = 1'b1; exp_addr = adr[8:1];
    end
    tick();
    if (is_miss(adr)) begin
      set_idle_exp();
      exp_err = 1'b1;
      tick();
    end else begin
      for (int j = 1; j <= n; j++) begin
        set_idle_exp();
        if (abort_k != 0 && j > abort_k) begin
          wb_cyc = 1'b0; wb_stb = 1'b0;
          tick();
          break;
        end
        exp_ack = 1'b1;
        exp_dat = ref_mem[wrap(a, n, j - 1)];
        if (j < n) begin
          exp_csb = 1'b0; exp_web = 1'b1;
          exp_addr = 8'(wrap(a, n, j) >> 1);
        end
        tick();
      end
    end
    bus_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    set_idle_exp();

    // Reset values with a request already on the bus.
    wb_cyc = 1'b1; wb_stb = 1'b1;
    #1;
    check("rst_ack", wb_ack, 0);
    check("rst_err", wb_err, 0);
    check("rst_dat", wb_o_dat, 0);
    check("rst_csb", o_sram_csb, 1);
    check("rst_web", o_sram_web, 1);
    check("rst_wmask", o_sram_wmask, 0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst = 1'b1;
    tick();
    set_idle_exp();
    chk_en = 1'b1;
    bus_idle();

    // High-lane full write then readback.
    do_write(24'h000003, 16'h00A5, 2'b11, 1'b0, 1'b0);
    do_read(24'h000003, 1'b0, 1'b0, 0);
    check("rd_a5_cnt", got.size(), 1);
    check("rd_a5", got[0], 16'h00A5);

    // Low-byte-only write leaves the high byte and the neighbouring halfword intact.
    do_write(24'h000002, 16'h1234, 2'b11, 1'b0, 1'b0);
    do_write(24'h000002, 16'hBEEF, 2'b01, 1'b1, 1'b0);
    do_read(24'h000002, 1'b0, 1'b0, 0);
    check("rd_12ef", got[0], 16'h12EF);
    do_read(24'h000003, 1'b0, 1'b0, 0);
    check("rd_a5_kept", got[0], 16'h00A5);
    do_write(24'h000004, 16'h7777, 2'b00, 1'b0, 1'b0);
    do_read(24'h000004, 1'b0, 1'b0, 0);
    check("sel0_nowrite", got[0], 16'h0000);

    // 8-beat wrapping burst.
    for (int i = 0; i < 8; i++) do_write(24'(i), 16'h1000 + 16'(i), 2'b11, i[0], i[1]);
    do_read(24'h000005, 1'b0, 1'b1, 0);
    check("b8_cnt", got.size(), 8);
    check("b8_beat0", got[0], 16'h1005);
    check("b8_beat2", got[2], 16'h1007);
    check("b8_beat3", got[3], 16'h1000);
    check("b8_beat7", got[7], 16'h1004);
    do_read(24'h000006, 1'b1, 1'b0, 0);
    check("b4_cnt", got.size(), 4);
    check("b4_beat2", got[2], 16'h1004);
    do_read(24'h000003, 1'b1, 1'b1, 0);
    check("both_flags_cnt", got.size(), 8);

    // Aborted burst, then a normal single read.
    do_read(24'h000000, 1'b1, 1'b0, 2);
    check("abort_cnt", got.size(), 2);
    check("abort_beat1", got[1], 16'h1001);
    do_read(24'h000006, 1'b0, 1'b0, 0);
    check("post_abort", got[0], 16'h1006);

    // Out-of-window access.
    do_read(24'h000200, 1'b0, 1'b0, 0);
`ifdef WB_SRAM_RESPONDER_WINDOW_CHECK_EN
    check("miss_no_ack", got.size(), 0);
`else
    check("alias_cnt", got.size(), 1);
    check("alias_dat", got[0], 16'h1000);
`endif

    // Asynchronous reset during beat 3 of a 4-beat burst.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 24'h000000; wb_4_burst = 1'b1; wb_8_burst = 1'b0;
    set_idle_exp();
    exp_csb = 1'b0; exp_addr = 8'h00;
    tick();
    for (int j = 1; j <= 2; j++) begin
      set_idle_exp();
      exp_ack = 1'b1; exp_dat = ref_mem[j - 1]; exp_csb = 1'b0; exp_addr = 8'(j >> 1);
      tick();
    end
    check("rst_mid_ack_pre", wb_ack, 1);
    chk_en = 1'b0;
    #1 i_rst = 1'b0;
    #1;
    check("rst_mid_ack", wb_ack, 0);
    check("rst_mid_err", wb_err, 0);
    check("rst_mid_dat", wb_o_dat, 0);
    check("rst_mid_csb", o_sram_csb, 1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_4_burst = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk) i_rst = 1'b1;
    tick();
    set_idle_exp();
    chk_en = 1'b1;
    do_read(24'h000002, 1'b0, 1'b0, 0);
    check("post_rst_rd", got[0], 16'h1002);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic [ADDR_W-1:0] adr;
      logic b4, b8;
      int n, k;
      adr = ($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'($urandom_range(0, 511));
      b4 = 1'($urandom); b8 = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_write(adr, 16'($urandom), 2'($urandom), b4, b8);
      end else begin
        n = b8 ? 8 : (b4 ? 4 : 1);
        k = (n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 1)) : 0;
        do_read(adr, b4, b8, k);
      end
      if ($urandom_range(0, 3) == 0) bus_idle();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
